// File: rtl/mux_rr_arb_if.sv
// Bus bundle for mux_rr_arb: per-channel producer handshakes on the input side,
// one registered consumer handshake on the output side.
interface mux_rr_arb_if #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);

    // Handshake rule on both sides: a beat moves on a rising clk edge exactly when
    // valid and ready are both high; valid never waits for ready, and out_data/out_ch
    // stay constant while out_valid is high and out_ready is low.
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_rr_arb.sv
// N-channel multiplexer with manual or round-robin selection and a single
// registered output stage that sustains one beat per cycle under backpressure.
module mux_rr_arb #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4
) (
    input logic         clk,
    input logic         rst_n,
    mux_rr_arb_if.slave bus
);
    localparam int SELW = $clog2(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic [SELW-1:0]  ptr;
    logic             load_en;
    logic             grant;
    logic [SELW-1:0]  g;
    logic [WIDTH-1:0] g_data;
    logic [NCH-1:0]   rot;

    // The output register can take a new beat when empty or being drained this cycle.
    assign load_en = !bus.out_valid || bus.out_ready;

    always_comb begin
        grant = 1'b0;
        g     = '0;
        rot   = NCH'({bus.in_valid, bus.in_valid} >> ptr);
        if (!bus.mode) begin
            for (int k = 0; k < NCH; k++) begin
                if (bus.sel == SELW'(k) && bus.in_valid[k]) begin
                    grant = 1'b1;
                    g     = SELW'(k);
                end
            end
        end else begin
            // rot[i] is the valid of channel (ptr+i) mod NCH; the lowest set bit wins.
            for (int i = NCH - 1; i >= 0; i--) begin
                if (rot[i]) begin
                    grant = 1'b1;
                    g     = (int'(ptr) + i >= NCH) ? SELW'(int'(ptr) + i - NCH)
                                                   : SELW'(int'(ptr) + i);
                end
            end
        end
    end

    always_comb begin
        g_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (g == SELW'(k)) begin
                g_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            bus.in_ready[k] = rst_n && load_en && grant && (g == SELW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            ptr           <= '0;
        end else if (load_en) begin
            if (grant) begin
                bus.out_data  <= g_data;
                bus.out_ch    <= g;
                bus.out_valid <= 1'b1;
                ptr           <= (g == LAST_CH) ? '0 : g + 1'b1;
            end else begin
                // Data and channel index keep their last value on an idle cycle.
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_arb.sv
// Bench for mux_rr_arb: a 4-channel and a 3-channel instance share stimulus and are
// checked against an arithmetic reference model through per-instance scoreboards.
module tb_mux_rr_arb;
  localparam int W  = 4;
  localparam int IW = 6;  // scoreboard item = {ch[1:0], data[3:0]}

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        mode;
  logic [1:0]  sel;
  logic [15:0] data;
  logic [3:0]  valid;
  logic        out_ready;

  mux_rr_arb_if #(.WIDTH(W), .NCH(4)) b4 ();
  mux_rr_arb_if #(.WIDTH(W), .NCH(3)) b3 ();

  assign b4.mode      = mode;
  assign b4.sel       = sel;
  assign b4.in_data   = data;
  assign b4.in_valid  = valid;
  assign b4.out_ready = out_ready;
  assign b3.mode      = mode;
  assign b3.sel       = sel;
  assign b3.in_data   = data[11:0];
  assign b3.in_valid  = valid[2:0];
  assign b3.out_ready = out_ready;

  mux_rr_arb #(.WIDTH(W), .NCH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  mux_rr_arb #(.WIDTH(W), .NCH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_q4[$];
  logic [IW-1:0] exp_q3[$];
  int            m_ptr[2];
  bit            m_valid[2];
  logic [IW-1:0] m_last[2];
  bit            m_init[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: called each negedge with the DUT view just before the next edge.
  task automatic model_step(input int u, input int n, input logic [3:0] rdy,
                            input logic ov, input logic [IW-1:0] oitem);
    bit            gr;
    bit            le;
    int            g;
    int            k;
    logic [31:0]   exp_rdy;
    logic [IW-1:0] item;
    string         tag;
    tag = (u == 0) ? "n4" : "n3";
    if (m_init[u]) begin
      chk({tag, " out_valid"}, 32'(ov), 32'(m_valid[u]));
      chk({tag, " out_ch_data"}, 32'(oitem), 32'(m_last[u]));
    end
    if (!rst_n) begin
      chk({tag, " in_ready_in_reset"}, 32'(rdy), 32'd0);
      m_valid[u] = 1'b0;
      m_last[u]  = '0;
      m_ptr[u]   = 0;
      m_init[u]  = 1'b1;
      if (u == 0) exp_q4.delete();
      else exp_q3.delete();
    end else begin
      gr = 1'b0;
      g  = 0;
      if (mode == 1'b0) begin
        if (int'(sel) < n && valid[sel]) begin
          gr = 1'b1;
          g  = int'(sel);
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          k = (m_ptr[u] + i) % n;
          if (!gr && valid[k]) begin
            gr = 1'b1;
            g  = k;
          end
        end
      end
      le      = !m_valid[u] || out_ready;
      exp_rdy = (le && gr) ? (32'd1 << g) : 32'd0;
      chk({tag, " in_ready"}, 32'(rdy), exp_rdy);
      if (le) begin
        if (gr) begin
          item = {2'(g), data[g*W +: W]};
          if (u == 0) exp_q4.push_back(item);
          else exp_q3.push_back(item);
          m_last[u]  = item;
          m_valid[u] = 1'b1;
          m_ptr[u]   = (g + 1) % n;
        end else begin
          m_valid[u] = 1'b0;
        end
      end
    end
  endtask

  task automatic mon_step(input int u, input logic ov, input logic [IW-1:0] oitem);
    logic [IW-1:0] e;
    string         tag;
    int            sz;
    tag = (u == 0) ? "n4" : "n3";
    sz  = (u == 0) ? exp_q4.size() : exp_q3.size();
    if (rst_n && ov === 1'b1) begin
      if (sz == 0) begin
        chk({tag, " unexpected_beat"}, 32'(oitem), 32'hFFFF_FFFF);
      end else begin
        e = (u == 0) ? exp_q4[0] : exp_q3[0];
        chk({tag, " beat"}, 32'(oitem), 32'(e));
        if (out_ready) begin
          if (u == 0) void'(exp_q4.pop_front());
          else void'(exp_q3.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 4, b4.in_ready, b4.out_valid, {b4.out_ch, b4.out_data});
    model_step(1, 3, {1'b0, b3.in_ready}, b3.out_valid, {b3.out_ch, b3.out_data});
  end

  always @(negedge clk) begin
    mon_step(0, b4.out_valid, {b4.out_ch, b4.out_data});
    mon_step(1, b3.out_valid, {b3.out_ch, b3.out_data});
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    data      = 16'($urandom);
    valid     = 4'hF;
    out_ready = 1'b1;
    cyc(2);
    rst_n = 1'b1;

    // manual selection, channel contents 5,3,0,1
    data = 16'h1035;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      cyc(1);
    end

    // dense round-robin
    mode = 1'b1;
    cyc(8);

    // sparse round-robin from ptr=0, then inputs go idle
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    valid = 4'b1010;
    cyc(4);
    valid = 4'b0000;
    cyc(2);

    // backpressure while holding a beat
    valid = 4'hF;
    cyc(2);
    out_ready = 1'b0;
    cyc(3);
    out_ready = 1'b1;
    cyc(2);

    // reset while stalled drops the held beat
    out_ready = 1'b0;
    cyc(2);
    rst_n = 1'b0;
    cyc(1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc(2);

    for (int t = 0; t < 500; t++) begin
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      data      = 16'($urandom);
      valid     = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 60) != 0);
      cyc(1);
    end

    rst_n     = 1'b1;
    out_ready = 1'b1;
    valid     = 4'h0;
    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
